multicycle_ctrl: RTL

- Multi-cycle sequencing FSM for the single-issue RV32 datapath.
- Replaces the single-cycle Control block by driving PC, instruction register, register-file, ALU-mux and data-memory enables one step at a time.
- Handles a variable-latency data memory with a ready handshake and a watchdog.
- Counts retired instructions.

---
 rtl/multicycle_ctrl_if.sv | 30 +++
 rtl/multicycle_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Data-memory handshake between the multi-cycle sequencer and the data memory.
//
// Signals:
//   MemRead_o    sequencer -> memory   read request, held until mem_ready_i
//   MemWrite_o   sequencer -> memory   write request, held until mem_ready_i
//   mem_ready_i  memory -> sequencer   current access has completed
//
// Modports:
//   master  the sequencer (drives requests, samples ready)
//   slave   the data memory (samples requests, drives ready)
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic MemRead_o;
  logic MemWrite_o;
  logic mem_ready_i;

  modport master (
    output MemRead_o,
    output MemWrite_o,
    input  mem_ready_i
  );

  modport slave (
    input  MemRead_o,
    input  MemWrite_o,
    output mem_ready_i
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle sequencing FSM for the single-issue RV32 datapath. Steps each
// instruction through FETCH / DECODE / EXEC / MEM / WB, driving one group of
// datapath enables per step, waits on a variable-latency data memory with a
// watchdog, and counts retired instructions.
//
// Parameters:
//   WAIT_MAX  cycles allowed in MEM without mem_ready_i before ERROR (1..255)
//   CNT_W     width of the retired-instruction counter
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   start_i      run enable (level); sampled in IDLE and at retire
//   op_i         instr[6:0], valid from the cycle after IRWrite_o
//   mem          data-memory handshake (MemRead_o, MemWrite_o, mem_ready_i)
//   PCWrite_o    PC update enable, one pulse per retired instruction
//   IRWrite_o    instruction register load enable (FETCH)
//   RegWrite_o   register file write enable (WB)
//   MemtoReg_o   WB mux select, 1 = memory, 0 = ALU
//   ALUSrc_o     ALU operand-2 select, 1 = immediate, 0 = RS2
//   ALUOp_o      10 = R-type, 00 = add/other, 01 = branch compare
//   Branch_o     branch-resolve cycle
//   busy_o       high in every state except IDLE and ERROR
//   err_o        sticky error flag, cleared only by reset
//   state_o      encoded current state (debug)
//   instr_cnt_o  retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [6:0]           op_i,
  multicycle_ctrl_if.master    mem,
  output logic                 PCWrite_o,
  output logic                 IRWrite_o,
  output logic                 RegWrite_o,
  output logic                 MemtoReg_o,
  output logic                 ALUSrc_o,
  output logic [1:0]           ALUOp_o,
  output logic                 Branch_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [2:0]           state_o,
  output logic [CNT_W-1:0]     instr_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd7
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Last wait-count value before the watchdog fires: the counter holds the
  // number of ready-less cycles already spent, so the WAIT_MAX-th such cycle
  // sees WAIT_MAX-1 here.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: is_legal = 1'b1;
      default:                                  is_legal = 1'b0;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             retire;

  logic             pc_write_q, pc_write_d;
  logic             ir_write_q, ir_write_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             alu_src_q, alu_src_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             branch_q, branch_d;
  logic             busy_q, busy_d;
  logic             store_done;

  // Sequencing: next state, opcode latch, MEM watchdog counter and the
  // retire bookkeeping. Retire is a single point so the counter update and
  // the start_i sample happen identically for every instruction class.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d    = op_i;
        state_d = is_legal(op_i) ? S_EXEC : S_ERROR;
      end
      S_EXEC: begin
        case (op_q)
          OP_R, OP_I:        state_d = S_WB;
          OP_LOAD, OP_STORE: begin
            state_d = S_MEM;
            wait_d  = 8'd0;
          end
          OP_BRANCH:         retire  = 1'b1;
          default:           state_d = S_ERROR;
        endcase
      end
      S_MEM: begin
        // Ready is checked before the watchdog so a completion on the last
        // allowed cycle still counts.
        if (mem.mem_ready_i) begin
          if (op_q == OP_LOAD) state_d = S_WB;
          else                 retire  = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) state_d = S_ERROR;
        end
      end
      S_WB: begin
        retire = 1'b1;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase

    if (retire) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = start_i ? S_FETCH : S_IDLE;
    end

    err_d = err_q | (state_d == S_ERROR);
  end

  // Output decode from the upcoming state and opcode, so that the registered
  // enables line up with state_q in the following cycle.
  always_comb begin
    pc_write_d   = 1'b0;
    ir_write_d   = 1'b0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_src_d    = 1'b0;
    alu_op_d     = 2'b00;
    branch_d     = 1'b0;
    busy_d       = (state_d != S_IDLE) && (state_d != S_ERROR);

    case (state_d)
      S_FETCH: begin
        ir_write_d = 1'b1;
      end
      S_EXEC: begin
        case (op_d)
          OP_R: begin
            alu_op_d  = 2'b10;
          end
          OP_I, OP_LOAD, OP_STORE: begin
            alu_op_d  = 2'b00;
            alu_src_d = 1'b1;
          end
          OP_BRANCH: begin
            alu_op_d   = 2'b01;
            branch_d   = 1'b1;
            pc_write_d = 1'b1;
          end
          default: begin
            alu_op_d = 2'b00;
          end
        endcase
      end
      S_MEM: begin
        mem_read_d  = (op_d == OP_LOAD);
        mem_write_d = (op_d == OP_STORE);
      end
      S_WB: begin
        reg_write_d  = 1'b1;
        pc_write_d   = 1'b1;
        mem_to_reg_d = (op_d == OP_LOAD);
      end
      default: begin
        busy_d = busy_d;
      end
    endcase
  end

  // State, latched opcode, counters and registered enables.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      op_q         <= 7'd0;
      wait_q       <= 8'd0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      pc_write_q   <= 1'b0;
      ir_write_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= 2'b00;
      branch_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wait_q       <= wait_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      pc_write_q   <= pc_write_d;
      ir_write_q   <= ir_write_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      alu_op_q     <= alu_op_d;
      branch_q     <= branch_d;
      busy_q       <= busy_d;
    end
  end

  // A store retires in the very MEM cycle its ready arrives, and that is the
  // only place the PC pulse cannot be known a cycle ahead. It is gated by the
  // registered state and opcode, so reset or any other state forces it low.
  assign store_done = (state_q == S_MEM) && (op_q == OP_STORE) && mem.mem_ready_i;

  assign PCWrite_o      = pc_write_q | store_done;
  assign IRWrite_o      = ir_write_q;
  assign RegWrite_o     = reg_write_q;
  assign MemtoReg_o     = mem_to_reg_q;
  assign ALUSrc_o       = alu_src_q;
  assign ALUOp_o        = alu_op_q;
  assign Branch_o       = branch_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;
  assign state_o        = state_q;
  assign instr_cnt_o    = cnt_q;
  assign mem.MemRead_o  = mem_read_q;
  assign mem.MemWrite_o = mem_write_q;

endmodule
